// File: rtl/axis_line_buffer.sv
// axis_line_buffer
//   Byte-wide AXI-stream line buffer that sits between the uart receiver and
//   the uart transmitter. It collects received bytes until TERM_CHAR arrives
//   (or the buffer fills), then replays the whole line to the transmitter.
//   Input is back-pressured while the line is being replayed.
//
// Parameters
//   ADDR_WIDTH  buffer depth = 2**ADDR_WIDTH bytes, terminator included
//   TERM_CHAR   line terminator byte
//
// Ports
//   clk                 system clock
//   rst                 asynchronous, active-high reset
//   input_axis_tdata    byte from uart rx
//   input_axis_tvalid   input byte valid
//   input_axis_tready   buffer accepts an input byte (FILL only)
//   output_axis_tdata   byte to uart tx (registered)
//   output_axis_tvalid  output byte valid (registered)
//   output_axis_tready  uart tx accepts byte
//   level               bytes currently held (line length while draining)
//   busy                high while draining
//   overflow            1-cycle pulse when a line is truncated at full
//
// Build option
//   LINE_BUFFER_BACKSPACE_EN: when defined, 8'h08 / 8'h7F received in FILL
//   erase the last stored byte instead of being stored.
//
// State table
//   S_FILL  | accepting bytes into the buffer, output idle
//   S_DRAIN | replaying buffer[0 .. level-1], input back-pressured

module axis_line_buffer #(
  parameter int         ADDR_WIDTH = 6,
  parameter logic [7:0] TERM_CHAR  = 8'h0D
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            input_axis_tdata,
  input  logic                  input_axis_tvalid,
  output logic                  input_axis_tready,
  output logic [7:0]            output_axis_tdata,
  output logic                  output_axis_tvalid,
  input  logic                  output_axis_tready,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  busy,
  output logic                  overflow
);

  localparam int              DEPTH   = 2 ** ADDR_WIDTH;
  localparam int              LW      = ADDR_WIDTH + 1;
  localparam logic [LW-1:0]   LVL_ONE = LW'(1);
  localparam logic [LW-1:0]   LVL_MAX = LW'(DEPTH - 1);

  typedef enum logic {
    S_FILL  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   level_q, level_d;
  logic [LW-1:0]   rd_idx_q, rd_idx_d;
  logic [7:0]      tdata_q, tdata_d;
  logic            tvalid_q, tvalid_d;
  logic            tready_q, tready_d;
  logic            ovf_q, ovf_d;

  logic [7:0]      mem [DEPTH];
  logic            wr_en;
  logic            in_hs;
  logic            out_hs;
  logic            is_term;
  logic            is_bs;

  assign in_hs   = input_axis_tvalid && tready_q;
  assign out_hs  = tvalid_q && output_axis_tready;
  assign is_term = (input_axis_tdata == TERM_CHAR);

`ifdef LINE_BUFFER_BACKSPACE_EN
  assign is_bs = (input_axis_tdata == 8'h08) || (input_axis_tdata == 8'h7F);
`else
  assign is_bs = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    rd_idx_d = rd_idx_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    ovf_d    = 1'b0;
    wr_en    = 1'b0;

    case (state_q)
      S_FILL: begin
        if (in_hs) begin
          if (is_bs) begin
            if (level_q != '0) begin
              level_d = level_q - LVL_ONE;
            end
          end else begin
            wr_en   = 1'b1;
            level_d = level_q + LVL_ONE;
            if (is_term || (level_q == LVL_MAX)) begin
              state_d  = S_DRAIN;
              ovf_d    = !is_term;
              tvalid_d = 1'b1;
              rd_idx_d = LVL_ONE;
              // A one-byte line has its only byte still on the input bus;
              // the buffer write lands on the same edge, so bypass it.
              tdata_d  = (level_q == '0) ? input_axis_tdata : mem[0];
            end
          end
        end
      end

      S_DRAIN: begin
        if (out_hs) begin
          // rd_idx_q is the index of the byte to present next; once it
          // reaches the line length the byte just taken was the last one.
          if (rd_idx_q == level_q) begin
            state_d  = S_FILL;
            tvalid_d = 1'b0;
            level_d  = '0;
            rd_idx_d = '0;
          end else begin
            tdata_d  = mem[rd_idx_q[ADDR_WIDTH-1:0]];
            rd_idx_d = rd_idx_q + LVL_ONE;
          end
        end
      end

      default: begin
        state_d = S_FILL;
      end
    endcase

    // Registered ready: low out of reset, high one cycle later in FILL.
    tready_d = (state_d == S_FILL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FILL;
      level_q  <= '0;
      rd_idx_q <= '0;
      tdata_q  <= 8'h00;
      tvalid_q <= 1'b0;
      tready_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      rd_idx_q <= rd_idx_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tready_q <= tready_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage carries no reset: contents are meaningless once level is zero.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[level_q[ADDR_WIDTH-1:0]] <= input_axis_tdata;
    end
  end

  assign input_axis_tready  = tready_q;
  assign output_axis_tdata  = tdata_q;
  assign output_axis_tvalid = tvalid_q;
  assign level              = level_q;
  assign busy               = (state_q == S_DRAIN);
  assign overflow           = ovf_q;

endmodule

// File: tb/tb_axis_line_buffer.sv
module tb_axis_line_buffer;

  localparam int         AW    = 6;
  localparam int         DEPTH = 64;
  localparam logic [7:0] CR    = 8'h0D;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [AW:0]   level;
  logic          busy;
  logic          ovf;

  axis_line_buffer #(.ADDR_WIDTH(AW), .TERM_CHAR(CR)) dut (
    .clk                (clk),
    .rst                (rst),
    .input_axis_tdata   (in_data),
    .input_axis_tvalid  (in_valid),
    .input_axis_tready  (in_ready),
    .output_axis_tdata  (out_data),
    .output_axis_tvalid (out_valid),
    .output_axis_tready (out_ready),
    .level              (level),
    .busy               (busy),
    .overflow           (ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  logic [7:0] line[$];      // bytes of the line being collected
  logic [7:0] expq[$];      // bytes still to be replayed
  logic [7:0] out_log[$];   // every byte seen leaving the DUT
  bit         m_drain = 0;
  int         m_linelen = 0;
  bit         first = 0;
  bit         ovf_pend = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_data = 8'h00;
  int         busy_cycles = 0;
  int         ovf_count = 0;
  int         rdy_mode = 0;

  function automatic void model_accept(logic [7:0] b);
`ifdef LINE_BUFFER_BACKSPACE_EN
    if (b == 8'h08 || b == 8'h7F) begin
      if (line.size() > 0) void'(line.pop_back());
      return;
    end
`endif
    line.push_back(b);
    if (b == CR || line.size() == DEPTH) begin
      if (b != CR) ovf_pend = 1;
      expq = line;
      m_linelen = line.size();
      line.delete();
      m_drain = 1;
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      line.delete(); expq.delete();
      m_drain = 0; m_linelen = 0; ovf_pend = 0; prev_stall = 0; first = 1;
      chk("rst_tready", in_ready, 0);
      chk("rst_tvalid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_level", level, 0);
      chk("rst_overflow", ovf, 0);
      chk("rst_tdata", out_data, 0);
    end else begin
      chk("tready", in_ready, (m_drain || first) ? 0 : 1);
      first = 0;
      chk("busy", busy, m_drain);
      chk("tvalid", out_valid, m_drain);
      chk("level", level, m_drain ? m_linelen : line.size());
      chk("overflow", ovf, ovf_pend);
      ovf_pend = 0;
      if (ovf) ovf_count++;
      if (busy) busy_cycles++;
      if (prev_stall) chk("stall_stable", out_data, prev_data);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (in_valid && in_ready) model_accept(in_data);
      if (out_valid && out_ready) begin
        out_log.push_back(out_data);
        if (expq.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          chk("out_data", out_data, expq[0]);
          void'(expq.pop_front());
          if (expq.size() == 0) m_drain = 0;
        end
      end
    end
  end

  // output-side ready pattern
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(1, 0));
        default: out_ready = !out_ready;
      endcase
    end
  end

  // ---------------- driver tasks (start/end at posedge+1) ----------------
  task automatic timeout_fail(string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int t = 0;
    repeat ($urandom_range(max_gap, 0)) begin @(posedge clk); #1; end
    in_data  = b;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 3000) begin timeout_fail("in_handshake"); break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    forever begin
      @(negedge clk);
      if (!busy && !out_valid && !m_drain) break;
      t++;
      if (t > 3000) begin timeout_fail("drain_done"); break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic send_str(input string s, input int max_gap);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], max_gap);
  endtask

  task automatic send_random(input int n, input int cr_pm);
    logic [7:0] b;
    int r;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(999, 0);
      if (r < cr_pm)            b = CR;
      else if (r < cr_pm + 40)  b = ($urandom_range(1, 0) == 1) ? 8'h08 : 8'h7F;
      else                      b = 8'($urandom_range(126, 32));
      send_byte(b, 2);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [7:0] bs_exp[$];

    // reset and ready rising one cycle after release
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); chk("ready_after_release_0", in_ready, 0);
    @(negedge clk); chk("ready_after_release_1", in_ready, 1);
    @(posedge clk); #1;

    // 1: "AB",CR with tready high
    rdy_mode = 0; out_log.delete(); busy_cycles = 0;
    send_str("AB", 0);
    send_byte(CR, 0);
    chk("t1_first_tvalid", out_valid, 1);
    chk("t1_first_tdata", out_data, 8'h41);
    chk("t1_level_drain", level, 3);
    wait_idle();
    chk("t1_nbytes", out_log.size(), 3);
    if (out_log.size() == 3) begin
      chk("t1_b0", out_log[0], 8'h41);
      chk("t1_b1", out_log[1], 8'h42);
      chk("t1_b2", out_log[2], 8'h0D);
    end
    chk("t1_busy_cycles", busy_cycles, 3);
    chk("t1_level_after", level, 0);

    // 2: empty line
    out_log.delete(); busy_cycles = 0;
    send_byte(CR, 0);
    wait_idle();
    chk("t2_nbytes", out_log.size(), 1);
    if (out_log.size() == 1) chk("t2_b0", out_log[0], 8'h0D);
    chk("t2_busy_cycles", busy_cycles, 1);

    // 3: overflow at full
    rdy_mode = 1; out_log.delete(); ovf_count = 0;
    for (int i = 0; i < 63; i++) send_byte(8'h30, 1);
    send_byte(8'h31, 1);
    chk("t3_level_full", level, 64);
    wait_idle();
    chk("t3_nbytes", out_log.size(), 64);
    if (out_log.size() == 64) begin
      chk("t3_first", out_log[0], 8'h30);
      chk("t3_last", out_log[63], 8'h31);
    end
    chk("t3_ovf_pulses", ovf_count, 1);

    // 4: stalled drain with input held valid
    rdy_mode = 2; out_log.delete();
    send_str("HELLO", 1);
    send_byte(CR, 0);
    in_data = 8'h99; in_valid = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      chk("t4_ready_low_in_drain", busy, 1);
      t++;
      if (t > 200) begin timeout_fail("t4_drain"); break; end
    end
    @(posedge clk); #1; in_valid = 1'b0;
    send_byte(CR, 0);
    wait_idle();
    chk("t4_nbytes", out_log.size(), 8);
    if (out_log.size() == 8) begin
      chk("t4_b4", out_log[4], 8'h4F);
      chk("t4_b6", out_log[6], 8'h99);
    end

    // 5: backspace handling
    rdy_mode = 1; out_log.delete();
    send_str("AX", 1); send_byte(8'h08, 1); send_str("B", 1); send_byte(CR, 1);
    wait_idle();
    send_byte(8'h08, 1); send_byte(CR, 1);
    wait_idle();
`ifdef LINE_BUFFER_BACKSPACE_EN
    bs_exp = '{8'h41, 8'h42, 8'h0D, 8'h0D};
`else
    bs_exp = '{8'h41, 8'h58, 8'h08, 8'h42, 8'h0D, 8'h08, 8'h0D};
`endif
    chk("t5_nbytes", out_log.size(), bs_exp.size());
    if (out_log.size() == bs_exp.size())
      for (int i = 0; i < bs_exp.size(); i++) chk("t5_byte", out_log[i], bs_exp[i]);

    // 6: reset during drain
    rdy_mode = 0; out_log.delete();
    send_str("ABCD", 0);
    send_byte(CR, 0);
    t = 0;
    forever begin
      @(negedge clk);
      if (out_log.size() >= 2) break;
      t++;
      if (t > 100) begin timeout_fail("t6_two_bytes"); break; end
    end
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("t6_tvalid_at_rst", out_valid, 0);
    chk("t6_busy_at_rst", busy, 0);
    chk("t6_level_at_rst", level, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_log.delete();
    send_str("Z", 0);
    send_byte(CR, 0);
    wait_idle();
    chk("t6_nbytes", out_log.size(), 2);
    if (out_log.size() == 2) begin
      chk("t6_b0", out_log[0], 8'h5A);
      chk("t6_b1", out_log[1], 8'h0D);
    end

    // randomized traffic: short lines, then long lines that hit full
    rdy_mode = 1;
    send_random(400, 80);
    send_random(200, 2);
    send_byte(CR, 1);
    wait_idle();
    chk("rand_model_idle", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
